variable_table_flip_ctrl: RTL and testbench

Sequencer in front of the variable table cluster. It runs the post-load random initialisation sweep over every variable address through the common AXI write port. It executes single-variable flip requests from the walk/select logic as a read-invert-write on all tables in lockstep. Outside those operations it passes clause-evaluator lookups through unchanged.

---
 rtl/variable_table_flip_ctrl.sv | 98 +++++++++
 tb/tb_variable_table_flip_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/variable_table_flip_ctrl.sv
// variable_table_flip_ctrl: init sweep, read-invert-write flips and evaluator pass-through for the variable table cluster
module variable_table_flip_ctrl #(
   parameter int VARIABLE_ADDRESS_WIDTH = 11,
   parameter int CLUSTER_SIZE = 40,
   parameter int NUM_VARIABLES = 2048,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic init_start_i,
   output logic init_busy_o,
   output logic init_done_o,
   input  logic flip_valid_i,
   output logic flip_ready_o,
   input  logic [VARIABLE_ADDRESS_WIDTH-1:0] flip_addr_i,
   output logic flip_done_o,
   output logic flip_old_value_o,
   output logic flip_err_o,
   input  logic eval_en_i,
   input  logic [CLUSTER_SIZE*VARIABLE_ADDRESS_WIDTH-1:0] eval_addr_mi,
   output logic eval_stall_o,
   output logic vt_axi_en_o,
   output logic vt_axi_wr_en_o,
   output logic [VARIABLE_ADDRESS_WIDTH-1:0] vt_axi_addr_o,
   output logic vt_axi_data_o,
   output logic vt_en_o,
   output logic vt_wr_en_o,
   output logic [CLUSTER_SIZE*VARIABLE_ADDRESS_WIDTH-1:0] vt_addr_mo,
   output logic vt_data_o,
   input  logic [CLUSTER_SIZE-1:0] vt_data_mi
);
   localparam int W = VARIABLE_ADDRESS_WIDTH;
   localparam logic [W:0] NV = (W+1)'(NUM_VARIABLES);
   localparam logic [W:0] LAST = (W+1)'(NUM_VARIABLES - 1);
   localparam logic [15:0] SEED = (LFSR_SEED == 16'd0) ? 16'd1 : LFSR_SEED;

   typedef enum logic [1:0] {IDLE, INIT, FLIP_RD, FLIP_WR} state_t;

   state_t state, state_nx;
   logic [W:0] cnt;
   logic [15:0] lfsr;
   logic [W-1:0] addr_q;
   logic init_done_q, done_q, err_q, old_q;
   logic accept, bad_addr, init_last, flipping;
   logic unused_data;

   assign unused_data = ^vt_data_mi[CLUSTER_SIZE-1:1];

   always_comb begin
      accept = state == IDLE && flip_valid_i && !init_start_i;
      // widened compare so NUM_VARIABLES = 2^W never reports an error
      bad_addr = {1'b0, flip_addr_i} >= NV;
      init_last = cnt == LAST;
      flipping = state == FLIP_RD || state == FLIP_WR;
      state_nx = state == IDLE ? (init_start_i ? INIT : (accept && !bad_addr) ? FLIP_RD : IDLE)
               : state == INIT ? (init_last ? IDLE : INIT)
               : state == FLIP_RD ? FLIP_WR : IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         cnt <= '0;
         lfsr <= SEED;
         addr_q <= '0;
         init_done_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
         old_q <= 1'b0;
      end else begin
         state <= state_nx;
         init_done_q <= state == INIT && init_last;
         done_q <= state == FLIP_WR || (accept && bad_addr);
         err_q <= accept && bad_addr;
         if (state == IDLE && init_start_i) cnt <= '0;
         else if (state == INIT) cnt <= cnt + 1'b1;
         if (state == INIT) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         if (accept) addr_q <= flip_addr_i;
         if (state == FLIP_WR) old_q <= vt_data_mi[0];
      end
   end

   assign init_busy_o = state == INIT;
   assign init_done_o = init_done_q;
   assign flip_ready_o = state == IDLE && !init_start_i;
   assign flip_done_o = done_q;
   assign flip_err_o = err_q;
   assign flip_old_value_o = old_q;
   assign eval_stall_o = state != IDLE;
   assign vt_axi_en_o = init_busy_o;
   assign vt_axi_wr_en_o = init_busy_o;
   assign vt_axi_addr_o = init_busy_o ? cnt[W-1:0] : '0;
   assign vt_axi_data_o = init_busy_o & lfsr[0];
   assign vt_en_o = state == IDLE ? eval_en_i : flipping;
   assign vt_wr_en_o = state == FLIP_WR;
   assign vt_addr_mo = state == IDLE ? eval_addr_mi : flipping ? {CLUSTER_SIZE{addr_q}} : '0;
   assign vt_data_o = state == FLIP_WR & ~vt_data_mi[0];
endmodule

// File: tb/tb_variable_table_flip_ctrl.sv
// tb_variable_table_flip_ctrl: directed scoreboard bench with a behavioural table cluster model
module tb_variable_table_flip_ctrl;
   localparam int W = 4;
   localparam int CS = 40;
   localparam int NV = 8;
   localparam logic [15:0] SEED = 16'hACE1;

   logic clk, rst, init_start, init_busy, init_done, flip_valid, flip_ready, flip_done, flip_old, flip_err;
   logic eval_en, eval_stall, axi_en, axi_wr, axi_data, vt_en, vt_wr, vt_data;
   logic [W-1:0] flip_addr, axi_addr;
   logic [CS*W-1:0] eval_addr, vt_addr, ea;
   logic [CS-1:0] rd;

   int checks = 0, fails = 0;
   logic [4:0] init_q[$];
   logic [1:0] flip_q[$];
   logic [15:0] ref_lfsr;
   logic ref_mem [0:15];
   logic last_old;
   logic tbl [0:15];
   logic [4:0] ie;
   logic [1:0] fe;

   variable_table_flip_ctrl #(.VARIABLE_ADDRESS_WIDTH(W), .CLUSTER_SIZE(CS), .NUM_VARIABLES(NV), .LFSR_SEED(SEED)) dut (
      .clk_i(clk), .rst_i(rst), .init_start_i(init_start), .init_busy_o(init_busy), .init_done_o(init_done),
      .flip_valid_i(flip_valid), .flip_ready_o(flip_ready), .flip_addr_i(flip_addr), .flip_done_o(flip_done),
      .flip_old_value_o(flip_old), .flip_err_o(flip_err), .eval_en_i(eval_en), .eval_addr_mi(eval_addr),
      .eval_stall_o(eval_stall), .vt_axi_en_o(axi_en), .vt_axi_wr_en_o(axi_wr), .vt_axi_addr_o(axi_addr),
      .vt_axi_data_o(axi_data), .vt_en_o(vt_en), .vt_wr_en_o(vt_wr), .vt_addr_mo(vt_addr),
      .vt_data_o(vt_data), .vt_data_mi(rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // all tables receive the same writes, so one array stands in for the cluster contents
   always @(posedge clk) begin
      if (axi_en && axi_wr) tbl[axi_addr] <= axi_data;
      if (vt_en) begin
         for (int i = 0; i < CS; i++) rd[i] <= tbl[vt_addr[i*W +: W]];
         if (vt_wr) tbl[vt_addr[W-1:0]] <= vt_data;
      end
   end

   task automatic chk(input string tag, input logic [CS*W-1:0] obs, input logic [CS*W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (axi_en) begin
         if (init_q.size() == 0) chk("init_unexpected", axi_en, 1'b0);
         else begin
            ie = init_q.pop_front();
            chk("init_write", {axi_wr, axi_addr, axi_data}, {1'b1, ie});
         end
      end
      if (flip_done) begin
         if (flip_q.size() == 0) chk("flip_unexpected", flip_done, 1'b0);
         else begin
            fe = flip_q.pop_front();
            chk("flip_result", {flip_old, flip_err}, fe);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_init(input int n);
      for (int a = 0; a < n; a++) begin
         init_q.push_back({4'(a), ref_lfsr[0]});
         ref_mem[a] = ref_lfsr[0];
         ref_lfsr = {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
      end
   endtask

   task automatic push_flip(input logic [W-1:0] a);
      flip_q.push_back({ref_mem[a], 1'b0});
      last_old = ref_mem[a];
      ref_mem[a] = ~ref_mem[a];
   endtask

   // full sweep; returns at the negedge of the init_done cycle
   task automatic run_init();
      push_init(NV);
      init_start = 1'b1;
      #1 chk("init_ready_low", flip_ready, 1'b0);
      tick();
      init_start = 1'b0;
      for (int k = 0; k < NV; k++) begin
         @(negedge clk);
         chk("init_state", {init_busy, eval_stall, vt_en, init_done, flip_ready}, 5'b11000);
         tick();
      end
      @(negedge clk);
      chk("init_done", {init_done, init_busy, eval_stall}, 3'b100);
   endtask

   // called right after the accept edge
   task automatic flip_phase(input logic [W-1:0] a, input logic nv);
      @(negedge clk);
      chk("flip_rd", {vt_en, vt_wr, eval_stall, flip_ready}, 4'b1010);
      chk("flip_rd_addr", vt_addr, {CS{a}});
      tick();
      @(negedge clk);
      chk("flip_wr", {vt_en, vt_wr, vt_data, eval_stall}, {3'b110 | {2'b00, nv}, 1'b1});
      chk("flip_wr_addr", vt_addr, {CS{a}});
      tick();
      @(negedge clk);
      chk("flip_done", {flip_done, eval_stall, flip_ready}, 3'b101);
   endtask

   task automatic do_flip(input logic [W-1:0] a);
      flip_valid = 1'b1;
      flip_addr = a;
      push_flip(a);
      #1 chk("flip_ready", flip_ready, 1'b1);
      tick();
      flip_valid = 1'b0;
      flip_phase(a, ref_mem[a]);
   endtask

   initial begin
      rst = 1'b1; init_start = 1'b0; flip_valid = 1'b0; flip_addr = '0; eval_en = 1'b0; eval_addr = '0;
      ref_lfsr = SEED;
      for (int i = 0; i < 16; i++) ref_mem[i] = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      chk("reset_outputs", {flip_ready, init_busy, init_done, flip_done, flip_err, flip_old, eval_stall,
                            axi_en, axi_wr, axi_data, vt_en, vt_wr, vt_data}, 13'b1000000000000);
      chk("reset_addr", {axi_addr, vt_addr}, '0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < CS; i++) ea[i*W +: W] = 4'((i * 7 + 3) % 16);
      eval_addr = ea;
      eval_en = 1'b1;
      @(negedge clk);
      chk("pass_addr", vt_addr, ea);
      chk("pass_ctrl", {vt_en, vt_wr, eval_stall, flip_ready}, 4'b1001);
      tick();
      // init and flip requested together: init wins, flip waits for IDLE
      flip_valid = 1'b1;
      flip_addr = 4'd5;
      run_init();
      push_flip(4'd5);
      tick();
      flip_valid = 1'b0;
      eval_en = 1'b0;
      flip_phase(4'd5, ref_mem[5]);
      do_flip(4'd5);
      flip_valid = 1'b1;
      flip_addr = 4'd9;
      flip_q.push_back({last_old, 1'b1});
      #1 chk("err_accept", {flip_ready, vt_en, vt_wr}, 3'b100);
      tick();
      flip_valid = 1'b0;
      @(negedge clk);
      chk("err_done", {flip_done, vt_en, vt_wr, eval_stall, flip_ready}, 5'b10001);
      tick();
      @(negedge clk);
      chk("err_pulse", flip_done, 1'b0);
      push_init(4);
      init_start = 1'b1;
      tick();
      init_start = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("rst_init", {init_busy, axi_en, eval_stall}, 3'b000);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_init_nodone", init_done, 1'b0);
      ref_lfsr = SEED;
      flip_valid = 1'b1;
      flip_addr = 4'd2;
      tick();
      flip_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("rst_flip", {vt_en, eval_stall, flip_ready, flip_done}, 4'b0010);
      tick();
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("rst_flip_nodone", flip_done, 1'b0);
         tick();
      end
      run_init();
      tick();
      do_flip(4'd5);
      do_flip(4'd3);
      tick();
      chk("init_q_empty", 32'(init_q.size()), 32'd0);
      chk("flip_q_empty", 32'(flip_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
